// File: rtl/spi_fpga_master_arbiter.sv
// Round-robin arbiter sharing one SPI_FPGA_MASTER core between NUM_REQ requesters.
// Define SPI_ARB_WATCHDOG_EN to add a transaction watchdog that aborts after TIMEOUT_CYCLES.
module spi_fpga_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int PACK_LENGTH    = 8,
  parameter int NUM_REQ_LOG_2  = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           IN_CLOCK,
  input  logic                           IN_RESET,
  input  logic [NUM_REQ-1:0]             IN_REQ,
  input  logic [NUM_REQ*PACK_LENGTH-1:0] IN_REQ_DATA,
  output logic [NUM_REQ-1:0]             OUT_GRANT,
  output logic [NUM_REQ-1:0]             OUT_DONE,
  output logic [PACK_LENGTH-1:0]         OUT_RX_DATA,
  output logic                           OUT_ERROR,
  output logic                           OUT_MASTER_LAUNCH,
  output logic [PACK_LENGTH-1:0]         OUT_MASTER_DATA,
  input  logic                           IN_MASTER_CS,
  input  logic [PACK_LENGTH-1:0]         IN_MASTER_RX_DATA,
  input  logic                           IN_MASTER_DONE,
  output logic [NUM_REQ-1:0]             OUT_SLAVE_CS
);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, FINISH} state_t;

  state_t                   state;
  logic [NUM_REQ_LOG_2-1:0] ptr;
  logic [NUM_REQ_LOG_2-1:0] owner;
  logic [NUM_REQ_LOG_2-1:0] pick;
  logic                     pick_valid;
  logic [NUM_REQ_LOG_2-1:0] scan_idx;
  int                       scan_sum;
  logic [PACK_LENGTH-1:0]   pick_word;

  // Only the granted slave follows the master CS; all others stay deselected.
  assign OUT_SLAVE_CS = ~OUT_GRANT | {NUM_REQ{IN_MASTER_CS}};

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    pick       = ptr;
    pick_valid = 1'b0;
    scan_sum   = 0;
    scan_idx   = '0;
    // Scan from the farthest slot down so the slot nearest the pointer wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_sum = int'(ptr) + k;
      if (scan_sum >= NUM_REQ) scan_sum = scan_sum - NUM_REQ;
      scan_idx = NUM_REQ_LOG_2'(scan_sum);
      if (IN_REQ[scan_idx]) begin
        pick       = scan_idx;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    pick_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == NUM_REQ_LOG_2'(i)) pick_word = IN_REQ_DATA[i*PACK_LENGTH +: PACK_LENGTH];
    end
  end

`ifdef SPI_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;

  // Expires on the edge where the counter would reach TIMEOUT_CYCLES; a real completion wins.
  assign wd_expire = ((state == LAUNCH) || (state == BUSY && !(IN_MASTER_DONE && IN_MASTER_CS)))
                     && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign OUT_ERROR = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      state             <= IDLE;
      ptr               <= '0;
      owner             <= '0;
      OUT_GRANT         <= '0;
      OUT_DONE          <= '0;
      OUT_RX_DATA       <= '0;
      OUT_MASTER_LAUNCH <= 1'b0;
      OUT_MASTER_DATA   <= '0;
`ifdef SPI_ARB_WATCHDOG_EN
      OUT_ERROR         <= 1'b0;
      wd_cnt            <= '0;
`endif
    end else begin
      OUT_DONE <= '0;
`ifdef SPI_ARB_WATCHDOG_EN
      OUT_ERROR <= 1'b0;
      if (state == LAUNCH || state == BUSY) wd_cnt <= wd_cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            OUT_GRANT         <= NUM_REQ'(1) << pick;
            owner             <= pick;
            OUT_MASTER_DATA   <= pick_word;
            OUT_MASTER_LAUNCH <= 1'b1;
            state             <= LAUNCH;
`ifdef SPI_ARB_WATCHDOG_EN
            wd_cnt            <= '0;
`endif
          end
        end
        LAUNCH: begin
          if (!IN_MASTER_CS) begin
            OUT_MASTER_LAUNCH <= 1'b0;
            state             <= BUSY;
          end
        end
        BUSY: begin
          if (IN_MASTER_DONE && IN_MASTER_CS) begin
            OUT_RX_DATA <= IN_MASTER_RX_DATA;
            OUT_DONE    <= OUT_GRANT;
            state       <= FINISH;
          end
        end
        FINISH: begin
          OUT_GRANT <= '0;
          ptr       <= (owner == NUM_REQ_LOG_2'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef SPI_ARB_WATCHDOG_EN
      if (wd_expire) begin
        OUT_ERROR         <= 1'b1;
        OUT_MASTER_LAUNCH <= 1'b0;
        state             <= FINISH;
      end
`endif
    end
  end

endmodule

// File: tb/tb_spi_fpga_master_arbiter.sv
// Self-checking bench: transaction-level arbiter model plus a behavioural SPI master stand-in.
module tb_spi_fpga_master_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant, done, slave_cs;
  logic [W-1:0]   rx_data, master_data, master_rx;
  logic           error, master_launch, master_cs, master_done;

  spi_fpga_master_arbiter #(.NUM_REQ(N), .PACK_LENGTH(W)) dut (
    .IN_CLOCK(clk), .IN_RESET(rst), .IN_REQ(req), .IN_REQ_DATA(req_data),
    .OUT_GRANT(grant), .OUT_DONE(done), .OUT_RX_DATA(rx_data), .OUT_ERROR(error),
    .OUT_MASTER_LAUNCH(master_launch), .OUT_MASTER_DATA(master_data),
    .IN_MASTER_CS(master_cs), .IN_MASTER_RX_DATA(master_rx), .IN_MASTER_DONE(master_done),
    .OUT_SLAVE_CS(slave_cs)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference model: who owns the bus, whether launch is pending, what is latched.
  int           m_owner = -1;
  int           m_ptr = 0;
  logic         m_launch = 1'b0;
  logic         m_fin = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_rx = '0;
  logic [N-1:0] m_done = '0;

  // Master stand-in state.
  int           mm_phase = 0;
  int           mm_cnt = 0;
  logic [W-1:0] last_mosi = '0;
  bit           force_rx = 1'b0;
  logic [W-1:0] forced_rx = '0;
  logic [N-1:0] last_cs_low = '1;
  logic [N-1:0] prev_grant = '0;
  int           grant_log[$];

  function automatic int rr_pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_index(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int p;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_launch = 1'b0; m_fin = 1'b0;
      m_data = '0; m_rx = '0; m_done = '0;
    end else begin
      m_done = '0;
      if (m_fin) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_fin   = 1'b0;
      end else if (m_owner < 0) begin
        p = rr_pick(req, m_ptr);
        if (p >= 0) begin
          m_owner  = p;
          m_launch = 1'b1;
          m_data   = req_data[p*W +: W];
        end
      end else if (m_launch) begin
        if (!master_cs) m_launch = 1'b0;
      end else if (master_done && master_cs) begin
        m_done[m_owner] = 1'b1;
        m_rx  = master_rx;
        m_fin = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_grant, exp_cs;
    exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    for (int i = 0; i < N; i++) exp_cs[i] = (i == m_owner) ? master_cs : 1'b1;
    check("grant", grant, exp_grant);
    check("launch", master_launch, m_launch);
    check("done", done, m_done);
    check("rx_data", rx_data, m_rx);
    check("error", error, 1'b0);
    check("slave_cs", slave_cs, exp_cs);
    if (m_owner >= 0) check("master_data", master_data, m_data);
  endtask

  task automatic master_step();
    if (rst) begin
      mm_phase = 0; master_cs = 1'b1; master_done = 1'b0;
      return;
    end
    master_done = 1'b0;
    master_rx   = W'($urandom);
    case (mm_phase)
      0: begin
        if (master_launch) begin
          mm_phase = 1; mm_cnt = $urandom_range(0, 2);
        end else if ($urandom_range(0, 7) == 0) begin
          master_done = 1'b1;  // stale done pulse, must be ignored
        end
      end
      1: begin
        if (mm_cnt == 0) begin
          master_cs = 1'b0; last_mosi = master_data;
          mm_phase = 2; mm_cnt = $urandom_range(1, 6);
        end else mm_cnt--;
      end
      default: begin
        if (mm_cnt == 0) begin
          master_cs = 1'b1; master_done = 1'b1;
          master_rx = force_rx ? forced_rx : W'($urandom);
          mm_phase = 0;
        end else mm_cnt--;
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    model_step();
    compare_all();
    if (!master_cs && m_owner >= 0) last_cs_low = slave_cs;
    if (prev_grant == '0 && grant != '0) grant_log.push_back(onehot_index(grant));
    prev_grant = grant;
    master_step();
  endtask

  task automatic wait_grant(input string name);
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (grant != '0) return;
    end
    bound_fail(name);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (done != '0) return;
    end
    bound_fail(name);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (grant == '0 && m_owner < 0) return;
    end
    bound_fail(name);
  endtask

  task automatic wait_master_busy(input string name);
    for (int i = 0; i < 20; i++) begin
      if (mm_phase == 2) return;
      cycle();
    end
    bound_fail(name);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; req = '1; req_data = '0;
    master_cs = 1'b1; master_done = 1'b0; master_rx = '0;

    // Reset held with all requests pending.
    repeat (3) cycle();
    check("reset_grant", grant, 4'b0000);
    check("reset_slave_cs", slave_cs, 4'b1111);
    check("reset_launch", master_launch, 1'b0);
    check("reset_master_data", master_data, 8'h00);
    check("reset_rx", rx_data, 8'h00);

    // Round-robin with every request held.
    rst = 1'b0;
    grant_log.delete();
    for (int i = 0; i < 200 && grant_log.size() < 5; i++) cycle();
    req = '0;
    if (grant_log.size() < 5) bound_fail("rr_five_grants");
    else for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
    wait_idle("rr_idle");

    // Single transfer to requester 2.
    req_data[2*W +: W] = 8'hEA;
    force_rx = 1'b1; forced_rx = 8'h53;
    req = 4'b0100;
    wait_grant("single_grant");
    check("single_grant_vec", grant, 4'b0100);
    check("single_master_data", master_data, 8'hEA);
    req = '0;
    wait_done("single_done");
    check("single_done_vec", done, 4'b0100);
    check("single_rx", rx_data, 8'h53);
    check("single_cs_pattern", last_cs_low, 4'b1011);
    cycle();
    check("single_done_pulse_len", done, 4'b0000);
    check("single_rx_hold", rx_data, 8'h53);
    force_rx = 1'b0;
    wait_idle("single_idle");

    // TX word frozen after grant.
    req_data[1*W +: W] = 8'h11;
    req = 4'b0010;
    wait_grant("freeze_grant");
    check("freeze_grant_vec", grant, 4'b0010);
    req = '0;
    cycle();
    req_data[1*W +: W] = 8'h22;
    wait_done("freeze_done");
    check("freeze_mosi", last_mosi, 8'h11);
    check("freeze_master_data", master_data, 8'h11);
    wait_idle("freeze_idle");

    // Request dropped while the transfer is in flight.
    req = 4'b1000;
    wait_grant("drop_grant");
    check("drop_grant_vec", grant, 4'b1000);
    wait_master_busy("drop_busy");
    cycle();
    req = '0;
    wait_done("drop_done");
    check("drop_done_vec", done, 4'b1000);
    wait_idle("drop_idle");
    req = 4'b0011;
    wait_grant("after_drop_grant");
    check("after_drop_grant_vec", grant, 4'b0001);
    req = '0;
    wait_idle("after_drop_idle");

    // Reset in the middle of a transfer.
    req = 4'b0100;
    wait_grant("midrst_grant");
    req = '0;
    wait_master_busy("midrst_busy");
    cycle();
    rst = 1'b1;
    cycle();
    check("midrst_grant_vec", grant, 4'b0000);
    check("midrst_slave_cs", slave_cs, 4'b1111);
    check("midrst_launch", master_launch, 1'b0);
    check("midrst_rx", rx_data, 8'h00);
    check("midrst_master_data", master_data, 8'h00);
    rst = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      if ($urandom_range(0, 1) == 0) req_data = (N*W)'($urandom);
      cycle();
    end
    req = '0;
    wait_idle("random_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_fpga_master_arbiter.md
Name: spi_fpga_master_arbiter

Overview:
Shares one SPI_FPGA_MASTER core between NUM_REQ requesters, each owning its own slave device, using round-robin arbitration.
- Latches the granted requester's TX word and drives the master's launch/data inputs.
- Steers the master's single CS onto the granted requester's slave-select line.
- Returns the received word with a one-cycle done pulse.
- Sits between user logic and SPI_FPGA_MASTER, in the same clock domain.

Parameters:
NUM_REQ, 4, number of requesters / slave-select lines (2..8)
PACK_LENGTH, 8, SPI word width; must match the master core
NUM_REQ_LOG_2, $clog2(NUM_REQ), index width
TIMEOUT_CYCLES, 4096, watchdog limit in IN_CLOCK cycles (used only with the optional feature)

Ports:
IN_CLOCK  input  1  system clock; all logic on rising edge
IN_RESET  input  1  synchronous, active-high reset
IN_REQ  input  NUM_REQ  per-requester request level
IN_REQ_DATA  input  NUM_REQ*PACK_LENGTH  TX words; requester i uses bits [i*PACK_LENGTH +: PACK_LENGTH]
OUT_GRANT  output  NUM_REQ  one-hot grant, held for the whole transaction
OUT_DONE  output  NUM_REQ  one-cycle pulse to the granted requester at completion
OUT_RX_DATA  output  PACK_LENGTH  last received word, valid from the OUT_DONE cycle until the next completion
OUT_ERROR  output  1  one-cycle pulse on watchdog abort (tied 0 without the feature)
OUT_MASTER_LAUNCH  output  1  to master IN_LAUNCH
OUT_MASTER_DATA  output  PACK_LENGTH  to master IN_DATA
IN_MASTER_CS  input  1  master CS, active low
IN_MASTER_RX_DATA  input  PACK_LENGTH  master OUT_RECEIVE_DATA
IN_MASTER_DONE  input  1  master OUT_ACTION_DONE
OUT_SLAVE_CS  output  NUM_REQ  per-slave CS, active low

Behaviour:
- Reset values:
  - Outputs: OUT_GRANT=0, OUT_DONE=0, OUT_RX_DATA=0, OUT_ERROR=0, OUT_MASTER_LAUNCH=0, OUT_MASTER_DATA=0, OUT_SLAVE_CS=all 1.
  - Internal: state=IDLE, round-robin pointer=0.
- OUT_SLAVE_CS[i] = IN_MASTER_CS when OUT_GRANT[i]=1, else 1. This path is combinational, so no CS glitch is added.
- FSM states: IDLE, LAUNCH, BUSY, FINISH.
- IDLE:
  - If any IN_REQ bit is set, pick the first set bit searching upward from the pointer, with wrap-around.
  - Next edge: register OUT_GRANT, latch that requester's IN_REQ_DATA into OUT_MASTER_DATA, set OUT_MASTER_LAUNCH=1, go to LAUNCH.
- LAUNCH:
  - Hold launch high until IN_MASTER_CS is sampled 0.
  - On that edge: OUT_MASTER_LAUNCH=0, go to BUSY.
- BUSY:
  - Wait for IN_MASTER_DONE=1 sampled together with IN_MASTER_CS=1.
  - Then: OUT_RX_DATA<=IN_MASTER_RX_DATA, the granted OUT_DONE bit=1 for one cycle, go to FINISH.
- FINISH (one cycle):
  - Clear OUT_GRANT.
  - Pointer <= granted index + 1, mod NUM_REQ.
  - Return to IDLE.
  - A requester re-arbitrates no earlier than the following cycle.
- Latency: grant one cycle after the request is seen in IDLE; launch asserts in the same cycle as the grant.
- Data capture: OUT_MASTER_DATA is frozen for the whole transaction. Later IN_REQ_DATA changes are ignored.
- Request dropped after grant: the transaction still completes and the done pulse is still issued. A request is not cancellable.
- Simultaneous requests: strict round-robin. Each requester is served at most once per NUM_REQ grants while others are waiting.
- IN_MASTER_DONE while in IDLE or LAUNCH: ignored.
- Reset mid-transaction:
  - All outputs take their reset values on the next edge, so launch drops and CS is forced high on all slaves.
  - The master core completes or aborts independently; the arbiter ignores stale done pulses while in IDLE.

Optional Feature:
SPI_ARB_WATCHDOG_EN:
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to LAUNCH and increments in LAUNCH and BUSY.
  - When it reaches TIMEOUT_CYCLES: OUT_ERROR pulses for one cycle, OUT_MASTER_LAUNCH=0, no OUT_DONE, OUT_RX_DATA unchanged, go to FINISH (the pointer still advances).
- When undefined: no counter exists and OUT_ERROR is tied 0. The FSM can wait indefinitely.

Test Plan:
- Reset: hold IN_RESET=1 for 3 cycles with IN_REQ=4'b1111 -> all outputs at reset values, OUT_SLAVE_CS=4'b1111, no launch.
- Single transfer: IN_REQ=4'b0100, data[2]=8'hEA, slave model returns 8'h53 -> OUT_GRANT=4'b0100, OUT_MASTER_DATA=8'hEA, only OUT_SLAVE_CS[2] toggles low, OUT_DONE=4'b0100 for one cycle, OUT_RX_DATA=8'h53.
- Round-robin: IN_REQ=4'b1111 held for 5 transactions -> grant order 0,1,2,3,0.
- Data freeze: change data[1] from 8'h11 to 8'h22 one cycle after grant -> MOSI carries 8'h11.
- Request drop: deassert IN_REQ[3] while in BUSY -> transfer completes, OUT_DONE[3] pulses, next grant goes to another requester.
- Watchdog (with SPI_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=64): tie IN_MASTER_CS=1 -> OUT_ERROR pulses once 64 cycles after the grant, no OUT_DONE, FSM returns to IDLE, pointer advanced.
